// File: rtl/scoreboard_regfile_pkg.sv
// Shared defaults and sizing helpers for the scoreboarded register file.
// Exports: WIDTH_DEF, DEPTH_DEF, aw_of(), cw_of().
package register_file_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;

    // Register address width; at least one bit.
    function automatic int aw_of(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Busy counter width: must hold the value DEPTH itself.
    function automatic int cw_of(input int depth);
        return aw_of(depth) + 1;
    endfunction

endpackage

// File: rtl/scoreboard_regfile_if.sv
// Port bundle for the scoreboarded register file.
// master: write/issue/read requests; slave: read data, busy flags, pending.
interface scoreboard_regfile_if
    import register_file_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = aw_of(DEPTH);
    localparam int CW = cw_of(DEPTH);

    logic             write;
    logic [AW-1:0]    wreg;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    rreg1;
    logic [AW-1:0]    rreg2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             issue;
    logic [AW-1:0]    ireg;
    logic             busy1;
    logic             busy2;
    logic             hazard;
    logic [CW-1:0]    pending;

    modport master (
        output write, wreg, wd, rreg1, rreg2, issue, ireg,
        input  rd1, rd2, busy1, busy2, hazard, pending
    );

    modport slave (
        input  write, wreg, wd, rreg1, rreg2, issue, ireg,
        output rd1, rd2, busy1, busy2, hazard, pending
    );

endinterface

// File: rtl/scoreboard_regfile_mux.sv
// One read port: storage select, write-through bypass, zero-register mask
// and busy qualification. Ports: regs/busy state in, rreg in, rd/rbusy out.
module regfile_bypass_mux #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int AW       = 3
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] regs,
    input  logic [DEPTH-1:0]            busy,
    input  logic                        wr_en,
    input  logic                        write,
    input  logic [AW-1:0]               wreg,
    input  logic [WIDTH-1:0]            wd,
    input  logic [AW-1:0]               rreg,
    output logic [WIDTH-1:0]            rd,
    output logic                        rbusy
);

    logic addr_hit;
    logic zero_rd;

    assign addr_hit = (wreg == rreg);
    assign zero_rd  = (ZERO_REG != 0) && (rreg == '0);

    always_comb begin
        rd = regs[rreg];
        // wr_en is already masked for register 0, so no bypass there
        if (wr_en && addr_hit)
            rd = wd;
        if (zero_rd)
            rd = '0;
    end

    // A write landing this cycle retires the producer early.
    assign rbusy = busy[rreg] && !(write && addr_hit);

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register busy scoreboard and pending counter.
// Ports: clock, reset (async active-low), bus (scoreboard_regfile_if.slave).
module scoreboard_regfile
    import register_file_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    scoreboard_regfile_if.slave   bus
);

    localparam int AW = aw_of(DEPTH);
    localparam int CW = cw_of(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;
    logic [DEPTH-1:0]            busy_nx;
    logic [CW-1:0]               pend;
    logic [CW-1:0]               pend_nx;

    logic wr_en;
    logic is_en;
    logic set_new;
    logic clr_new;
    logic rb1;
    logic rb2;

    // Register 0 swallows writes and issues when hardwired to zero.
    assign wr_en = bus.write &&
                   !((ZERO_REG != 0) && (bus.wreg == '0));
    assign is_en = bus.issue &&
                   !((ZERO_REG != 0) && (bus.ireg == '0));

    // Only real bit transitions move the counter; issue beats write.
    assign set_new = is_en && !busy[bus.ireg];
    assign clr_new = wr_en && busy[bus.wreg] &&
                     !(is_en && (bus.ireg == bus.wreg));

    always_comb begin
        busy_nx = busy;
        if (wr_en)
            busy_nx[bus.wreg] = 1'b0;
        if (is_en)
            busy_nx[bus.ireg] = 1'b1;
    end

    always_comb begin
        pend_nx = pend;
        unique case ({set_new, clr_new})
            2'b10:   pend_nx = pend + 1'b1;
            2'b01:   pend_nx = pend - 1'b1;
            default: pend_nx = pend;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs <= '0;
            busy <= '0;
            pend <= '0;
        end else begin
            if (wr_en)
                regs[bus.wreg] <= bus.wd;
            busy <= busy_nx;
            pend <= pend_nx;
        end
    end

    regfile_bypass_mux #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_port1 (
        .regs  (regs),
        .busy  (busy),
        .wr_en (wr_en),
        .write (bus.write),
        .wreg  (bus.wreg),
        .wd    (bus.wd),
        .rreg  (bus.rreg1),
        .rd    (bus.rd1),
        .rbusy (rb1)
    );

    regfile_bypass_mux #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_port2 (
        .regs  (regs),
        .busy  (busy),
        .wr_en (wr_en),
        .write (bus.write),
        .wreg  (bus.wreg),
        .wd    (bus.wd),
        .rreg  (bus.rreg2),
        .rd    (bus.rd2),
        .rbusy (rb2)
    );

    assign bus.busy1   = rb1;
    assign bus.busy2   = rb2;
    assign bus.hazard  = rb1 | rb2;
    assign bus.pending = pend;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed self-checking bench for scoreboard_regfile.
// Drives on the falling edge, checks away from the rising edge.
module tb_scoreboard_regfile;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    scoreboard_regfile_if #(.WIDTH(16), .DEPTH(8)) bus ();

    scoreboard_regfile #(
        .WIDTH    (16),
        .DEPTH    (8),
        .ZERO_REG (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.write = 1'b0;
        bus.wreg  = '0;
        bus.wd    = '0;
        bus.issue = 1'b0;
        bus.ireg  = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        idle();
        bus.rreg1 = 3'd3;
        bus.rreg2 = 3'd5;
        #1;
        chk("rst_rd1", 32'(bus.rd1), 32'h0);
        chk("rst_rd2", 32'(bus.rd2), 32'h0);
        chk("rst_hazard", 32'(bus.hazard), 32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);

        // activity during reset is discarded
        @(negedge clock);
        bus.write = 1'b1; bus.wreg = 3'd3; bus.wd = 16'hBEEF;
        bus.issue = 1'b1; bus.ireg = 3'd5;
        tick();
        tick();
        chk("rst_pend_hold", 32'(bus.pending), 32'h0);
        idle();
        reset = 1'b1;
        #1;
        chk("rst_wr_drop", 32'(bus.rd1), 32'h0);
        chk("rst_iss_drop", 32'(bus.busy2), 32'h0);

        // write reg3, read next cycle
        @(negedge clock);
        bus.write = 1'b1; bus.wreg = 3'd3; bus.wd = 16'hAAAA;
        tick();
        idle();
        #1;
        chk("rd1_reg3", 32'(bus.rd1), 32'hAAAA);

        // bypass on reg5
        @(negedge clock);
        bus.write = 1'b1; bus.wreg = 3'd5; bus.wd = 16'h5555;
        #1;
        chk("bypass_rd2", 32'(bus.rd2), 32'h5555);
        tick();
        idle();
        #1;
        chk("stored_rd2", 32'(bus.rd2), 32'h5555);

        // register 0 is inert
        @(negedge clock);
        bus.rreg1 = 3'd0;
        bus.write = 1'b1; bus.wreg = 3'd0; bus.wd = 16'hFFFF;
        bus.issue = 1'b1; bus.ireg = 3'd0;
        #1;
        chk("zero_nobypass", 32'(bus.rd1), 32'h0);
        tick();
        idle();
        #1;
        chk("zero_rd1", 32'(bus.rd1), 32'h0);
        chk("zero_pend", 32'(bus.pending), 32'h0);
        chk("zero_busy", 32'(bus.busy1), 32'h0);

        // issue 2, 4, 6
        @(negedge clock);
        bus.issue = 1'b1; bus.ireg = 3'd2;
        tick();
        bus.ireg = 3'd4;
        tick();
        bus.ireg = 3'd6;
        tick();
        idle();
        bus.rreg1 = 3'd4;
        bus.rreg2 = 3'd2;
        #1;
        chk("pend3", 32'(bus.pending), 32'd3);
        chk("busy1_r4", 32'(bus.busy1), 32'h1);
        chk("busy2_r2", 32'(bus.busy2), 32'h1);
        chk("hazard_on", 32'(bus.hazard), 32'h1);

        // retire reg4: busy drops same cycle
        @(negedge clock);
        bus.write = 1'b1; bus.wreg = 3'd4; bus.wd = 16'h0044;
        #1;
        chk("busy1_wr", 32'(bus.busy1), 32'h0);
        chk("hazard_r2", 32'(bus.hazard), 32'h1);
        chk("pend_pre", 32'(bus.pending), 32'd3);
        tick();
        idle();
        #1;
        chk("pend2", 32'(bus.pending), 32'd2);
        chk("rd1_r4", 32'(bus.rd1), 32'h0044);

        // issue and write the same non-busy reg1
        @(negedge clock);
        bus.rreg1 = 3'd1;
        bus.write = 1'b1; bus.wreg = 3'd1; bus.wd = 16'h1111;
        bus.issue = 1'b1; bus.ireg = 3'd1;
        tick();
        idle();
        #1;
        chk("iw_pend", 32'(bus.pending), 32'd3);
        chk("iw_busy", 32'(bus.busy1), 32'h1);
        chk("iw_data", 32'(bus.rd1), 32'h1111);

        // write non-busy reg3, issue already-busy reg6
        @(negedge clock);
        bus.write = 1'b1; bus.wreg = 3'd3; bus.wd = 16'h1234;
        bus.issue = 1'b1; bus.ireg = 3'd6;
        tick();
        idle();
        #1;
        chk("nochg_pend", 32'(bus.pending), 32'd3);

        // issue reg3 and retire reg6 together
        @(negedge clock);
        bus.write = 1'b1; bus.wreg = 3'd6; bus.wd = 16'h0066;
        bus.issue = 1'b1; bus.ireg = 3'd3;
        tick();
        idle();
        bus.rreg1 = 3'd3;
        bus.rreg2 = 3'd6;
        #1;
        chk("swap_pend", 32'(bus.pending), 32'd3);
        chk("swap_b3", 32'(bus.busy1), 32'h1);
        chk("swap_b6", 32'(bus.busy2), 32'h0);
        chk("swap_rd1", 32'(bus.rd1), 32'h1234);

        // reset mid-cycle with work outstanding
        @(negedge clock);
        bus.issue = 1'b1; bus.ireg = 3'd5;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rd1", 32'(bus.rd1), 32'h0);
        chk("mid_pend", 32'(bus.pending), 32'h0);
        chk("mid_hazard", 32'(bus.hazard), 32'h0);
        @(negedge clock);
        idle();
        reset = 1'b1;
        tick();
        #1;
        chk("post_rd1", 32'(bus.rd1), 32'h0);
        chk("post_pend", 32'(bus.pending), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter WIDTH, default 16: data width of every register, in bits.
REQ-002 Parameter DEPTH, default 8: number of registers; a power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero and is never written or marked busy.
REQ-004 Derived constant AW = log2(DEPTH): register address width.
REQ-005 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port write, input, 1 bit: write enable for this cycle.
REQ-008 Port wreg, input, AW bits: write address.
REQ-009 Port wd, input, WIDTH bits: write data.
REQ-010 Port rreg1 and port rreg2, inputs, AW bits each: read addresses.
REQ-011 Port rd1 and port rd2, outputs, WIDTH bits each: read data.
REQ-012 Port issue, input, 1 bit: marks register ireg as having a pending producer.
REQ-013 Port ireg, input, AW bits: issue destination address.
REQ-014 Port busy1 and port busy2, outputs, 1 bit each: the operand at rreg1 or rreg2 is still pending.
REQ-015 Port hazard, output, 1 bit: busy1 OR busy2.
REQ-016 Port pending, output, log2(DEPTH)+1 bits: number of busy registers.

Function
REQ-017 Storage SHALL be DEPTH registers of WIDTH bits; on a clock edge with write=1, wd SHALL be stored at wreg.
REQ-018 Reads SHALL be combinational, with zero cycles of latency.
REQ-019 When write=1 and wreg equals rreg1 or rreg2, the matching rd SHALL show wd in the same cycle (write-through bypass).
REQ-020 With ZERO_REG=1: a read of address 0 SHALL return 0; a write to address 0 SHALL have no effect and SHALL NOT be bypassed; an issue to address 0 SHALL have no effect.
REQ-021 The scoreboard SHALL hold one busy bit per register.
REQ-022 An issue SHALL set busy[ireg] at the next clock edge.
REQ-023 A write SHALL clear busy[wreg] at the next clock edge.
REQ-024 When issue and write target the same register in the same edge, the issue SHALL win and the busy bit SHALL end at 1; the data write still occurs.
REQ-025 An issue to a register that is already busy SHALL leave the bit at 1 and SHALL NOT change pending.
REQ-026 A write to a register that is not busy SHALL leave the bit at 0 and SHALL NOT change pending.
REQ-027 busyN SHALL equal busy[rregN] AND NOT (write AND wreg==rregN); it is combinational.
REQ-028 pending SHALL be a registered up/down counter:
  - +1 on a 0->1 busy transition;
  - -1 on a 1->0 busy transition;
  - net 0 when both transitions happen on different registers in the same edge.
REQ-029 pending SHALL always equal the population count of the busy bits, never exceed DEPTH (or DEPTH-1 with ZERO_REG=1), and never underflow.

Reset
REQ-030 While reset=0, asynchronously, all registers, all busy bits and pending SHALL clear to 0, so rd1=rd2=0, busy1=busy2=0 and hazard=0.
REQ-031 Writes and issues presented while reset=0 SHALL be discarded, including a reset asserted mid-sequence with busy bits outstanding.
REQ-032 Normal operation SHALL resume on the first rising clock edge after reset returns to 1.

Structure
REQ-033 The package register_file_pkg SHALL hold the WIDTH and DEPTH defaults and the address-width and counter-width helper functions.
REQ-034 One sub-module, regfile_bypass_mux, SHALL implement one read port: storage select, zero-register masking, write-through bypass and the busy qualification; it SHALL be instantiated twice.

Verification
REQ-035 Reset, then write reg3=0xAAAA and read rreg1=3 on the next cycle -> rd1=0xAAAA.
REQ-036 Set write=1, wreg=5, wd=0x5555 and rreg2=5 in the same cycle -> rd2=0x5555 before the clock edge (bypass).
REQ-037 Write reg0=0xFFFF and issue ireg=0 with ZERO_REG=1 -> rd1=0 for rreg1=0, and pending=0.
REQ-038 Issue regs 2, 4 and 6 on consecutive cycles -> pending=3 and busy1=1 for rreg1=4; then write reg4 -> busy1=0 in the same cycle and pending=2 after the edge.
REQ-039 Issue and write reg2 in the same cycle while reg2 is not busy -> busy[2]=1, pending rises by 1, and the data is stored.
REQ-040 With pending=3 and reg3=0x1234, drive reset low mid-cycle -> all outputs are 0 immediately; after release, rd1=0 for rreg1=3 and pending=0.
